// File: rtl/mips_enc_pkg.sv
// Shared MIPS-32 encoder constants: mnemonic codes, opcode/funct values and
// loader FSM states. The decoder bench imports the same definitions.
package mips_enc_pkg;

    typedef enum logic [4:0] {
        MN_NOP   = 5'd0,
        MN_ADD   = 5'd1,
        MN_ADDU  = 5'd2,
        MN_SUB   = 5'd3,
        MN_SUBU  = 5'd4,
        MN_AND   = 5'd5,
        MN_OR    = 5'd6,
        MN_XOR   = 5'd7,
        MN_SLT   = 5'd8,
        MN_SLTU  = 5'd9,
        MN_SLL   = 5'd10,
        MN_SRL   = 5'd11,
        MN_SRA   = 5'd12,
        MN_ADDI  = 5'd13,
        MN_ADDIU = 5'd14,
        MN_SLTI  = 5'd15,
        MN_SLTIU = 5'd16,
        MN_ANDI  = 5'd17,
        MN_ORI   = 5'd18,
        MN_XORI  = 5'd19,
        MN_LW    = 5'd20,
        MN_SW    = 5'd21,
        MN_BEQ   = 5'd22,
        MN_BNE   = 5'd23,
        MN_J     = 5'd24
    } mnem_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mips_instr_encoder_fifo.sv
// Synchronous show-ahead FIFO (module enc_fifo): the head word is visible on
// popData whenever empty is low. DEPTH must be a power of two.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wrPtr;
    logic [PW:0]      rdPtr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full)
                wrPtr <= wrPtr + 1'b1;
            if (pop && !empty)
                rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wrPtr[PW-1:0]] <= pushData;
    end

    assign popData = mem[rdPtr[PW-1:0]];
    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);

endmodule

// File: rtl/mips_instr_encoder.sv
// Symbolic MIPS-32 instruction encoder and instruction-memory loader.
// Optional build macro ENC_ILLEGAL_CHECK_EN drops malformed instructions and flags err.
module mips_instr_encoder
    import mips_enc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    // Field forcing: arithmetic R-types drop shamt, shifts drop rs.
    function automatic logic [31:0] encodeWord(input logic [4:0] mnem, input logic [4:0] rs,
            input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] shamt,
            input logic [15:0] imm, input logic [25:0] target);
        logic [31:0] arith;
        logic [31:0] shift;
        arith = {OP_RTYPE, rs, rt, rd, 5'd0, 6'd0};
        shift = {OP_RTYPE, 5'd0, rt, rd, shamt, 6'd0};
        case (mnem)
            MN_ADD:   return arith | {26'd0, FN_ADD};
            MN_ADDU:  return arith | {26'd0, FN_ADDU};
            MN_SUB:   return arith | {26'd0, FN_SUB};
            MN_SUBU:  return arith | {26'd0, FN_SUBU};
            MN_AND:   return arith | {26'd0, FN_AND};
            MN_OR:    return arith | {26'd0, FN_OR};
            MN_XOR:   return arith | {26'd0, FN_XOR};
            MN_SLT:   return arith | {26'd0, FN_SLT};
            MN_SLTU:  return arith | {26'd0, FN_SLTU};
            MN_SLL:   return shift | {26'd0, FN_SLL};
            MN_SRL:   return shift | {26'd0, FN_SRL};
            MN_SRA:   return shift | {26'd0, FN_SRA};
            MN_ADDI:  return {OP_ADDI,  rs, rt, imm};
            MN_ADDIU: return {OP_ADDIU, rs, rt, imm};
            MN_SLTI:  return {OP_SLTI,  rs, rt, imm};
            MN_SLTIU: return {OP_SLTIU, rs, rt, imm};
            MN_ANDI:  return {OP_ANDI,  rs, rt, imm};
            MN_ORI:   return {OP_ORI,   rs, rt, imm};
            MN_XORI:  return {OP_XORI,  rs, rt, imm};
            MN_LW:    return {OP_LW,    rs, rt, imm};
            MN_SW:    return {OP_SW,    rs, rt, imm};
            MN_BEQ:   return {OP_BEQ,   rs, rt, imm};
            MN_BNE:   return {OP_BNE,   rs, rt, imm};
            MN_J:     return {OP_J, target};
            default:  return 32'h0000_0000;
        endcase
    endfunction

`ifdef ENC_ILLEGAL_CHECK_EN
    function automatic logic isLegal(input logic [4:0] mnem, input logic [4:0] rs,
            input logic [4:0] shamt);
        if (mnem > 5'(MN_J))
            return 1'b0;
        if (mnem >= 5'(MN_ADD) && mnem <= 5'(MN_SLTU))
            return shamt == 5'd0;
        if (mnem >= 5'(MN_SLL) && mnem <= 5'(MN_SRA))
            return rs == 5'd0;
        return 1'b1;
    endfunction
`endif

    state_t      state;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] encWord;
    logic [31:0] fifoHead;

    assign encWord = encodeWord(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
    assign accept  = in_valid && in_ready;
`ifdef ENC_ILLEGAL_CHECK_EN
    assign push    = accept && isLegal(in_mnem, in_rs, in_shamt);
`else
    assign push    = accept;
`endif
    assign pop     = !fifoEmpty && imem_ready;

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushData (encWord),
        .pop      (pop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign in_ready   = (state == ST_LOAD) && !fifoFull;
    assign imem_we    = !fifoEmpty;
    assign imem_wdata = fifoEmpty ? 32'h0000_0000 : fifoHead;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    // Session control plus write-address bookkeeping; a new session clears the
    // address, counter and sticky flags, overriding any same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            imem_addr <= ADDR_W'(BASE_ADDR);
            word_cnt  <= '0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (pop) begin
                imem_addr <= imem_addr + 1'b1;
                word_cnt  <= word_cnt + 1'b1;
                if (&imem_addr)
                    wrap <= 1'b1;
            end
`ifdef ENC_ILLEGAL_CHECK_EN
            if (accept && !push)
                err <= 1'b1;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        imem_addr <= ADDR_W'(BASE_ADDR);
                        word_cnt  <= '0;
                        wrap      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                ST_LOAD:  if (flush) state <= ST_DRAIN;
                ST_DRAIN: if (fifoEmpty) state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: queue-based reference model compared
// every cycle, plus directed literal checks. Honours ENC_ILLEGAL_CHECK_EN.
module tb_mips_instr_encoder;
    import mips_enc_pkg::*;

    localparam int FD   = 4;
    localparam int AW   = 2;
    localparam int BASE = 0;
`ifdef ENC_ILLEGAL_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, flush = 1'b0, in_valid = 1'b0, imem_ready = 1'b1;
    logic [4:0]    in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          in_ready, imem_we, busy, done, wrap, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_cnt;

    mips_instr_encoder #(.FIFO_DEPTH(FD), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .imem_we(imem_we),
        .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .wrap(wrap), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instruction table indexed by mnemonic: kind 0=nop 1=arith R 2=shift 3=I 4=J.
    int kindTab[25] = '{0, 1,1,1,1,1,1,1,1,1, 2,2,2, 3,3,3,3,3,3,3,3,3,3,3, 4};
    int codeTab[25] = '{0, 32,33,34,35,36,37,38,42,43, 0,2,3,
                        8,9,10,11,12,13,14,35,43,4,5, 2};

    function automatic void modelEncode(input int mn, input bit [4:0] rs, input bit [4:0] rt,
            input bit [4:0] rd, input bit [4:0] sh, input bit [15:0] imm, input bit [25:0] tgt,
            output bit pushIt, output bit [31:0] w);
        int  kind;
        bit  legal;
        bit [31:0] code;
        legal = 1'b1;
        w     = 32'h0;
        kind  = (mn > 24) ? -1 : kindTab[mn];
        code  = (mn > 24) ? 32'h0 : 32'(codeTab[mn]);
        case (kind)
            -1: legal = 1'b0;
            1: begin
                if (sh != 0) legal = 1'b0;
                w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | code;
            end
            2: begin
                if (rs != 0) legal = 1'b0;
                w = (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | code;
            end
            3: w = (code << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            4: w = (32'd2 << 26) | 32'(tgt);
            default: w = 32'h0;
        endcase
        pushIt = legal || !CHECK_EN;
    endfunction

    int        phase = P_IDLE;
    bit [31:0] q[$];
    int        mAddr = BASE;
    int        mCnt = 0;
    bit        mWrap = 1'b0, mErr = 1'b0, modelValid = 1'b0;
    bit        mPush, wasEmpty, canAcc;
    bit [31:0] mWord;

    // Reference model advances on each rising edge from the driven inputs.
    always @(posedge clk) begin
        if (rst) begin
            phase = P_IDLE; q.delete(); mAddr = BASE; mCnt = 0;
            mWrap = 1'b0; mErr = 1'b0; modelValid = 1'b1;
        end else if (modelValid) begin
            wasEmpty = (q.size() == 0);
            canAcc   = (phase == P_LOAD) && (q.size() < FD);
            modelEncode(int'(in_mnem), in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, mPush, mWord);
            if (!wasEmpty && imem_ready) begin
                void'(q.pop_front());
                if (mAddr == (1 << AW) - 1) begin mAddr = 0; mWrap = 1'b1; end
                else mAddr = mAddr + 1;
                mCnt = (mCnt + 1) % (1 << (AW + 1));
            end
            case (phase)
                P_IDLE: if (start) begin
                    phase = P_LOAD; mAddr = BASE; mCnt = 0; mWrap = 1'b0; mErr = 1'b0;
                end
                P_LOAD:  if (flush) phase = P_DRAIN;
                P_DRAIN: if (wasEmpty) phase = P_DONE;
                default: phase = P_IDLE;
            endcase
            if (canAcc && in_valid) begin
                if (mPush) q.push_back(mWord);
                else mErr = 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (modelValid) begin
            bit        eReady, eWe;
            bit [31:0] eData;
            eReady = (phase == P_LOAD) && (q.size() < FD);
            eWe    = (q.size() != 0);
            eData  = eWe ? q[0] : 32'h0;
            tests++;
            if (in_ready !== eReady || imem_we !== eWe || imem_wdata !== eData ||
                imem_addr !== AW'(mAddr) || word_cnt !== (AW+1)'(mCnt) ||
                busy !== (phase != P_IDLE) || done !== (phase == P_DONE) ||
                wrap !== mWrap || err !== mErr) begin
                fails++;
                $display("[TB] FAIL cycleModel t=%0t got rdy=%b we=%b a=%0d d=%h cnt=%0d busy=%b done=%b wrap=%b err=%b; want rdy=%b we=%b a=%0d d=%h cnt=%0d busy=%b done=%b wrap=%b err=%b",
                         $time, in_ready, imem_we, imem_addr, imem_wdata, word_cnt, busy, done, wrap, err,
                         eReady, eWe, mAddr, eData, mCnt, phase != P_IDLE, phase == P_DONE, mWrap, mErr);
            end
        end
    end

    logic [AW-1:0] logAddr[$];
    logic [31:0]   logData[$];

    always @(posedge clk) begin
        if (!rst && imem_we && imem_ready) begin
            logAddr.push_back(imem_addr);
            logData.push_back(imem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
            input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt);
        bit ok;
        ok = 1'b0;
        in_mnem = mn; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) checkOutput("acceptTimeout", 32'(ok), 32'd1);
    endtask

    task automatic startSession();
        logAddr.delete();
        logData.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic endSession();
        bit seen;
        seen = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        imem_ready = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        checkOutput("donePulse", 32'(seen), 32'd1);
        tick();
        checkOutput("doneOneCycle", 32'(done), 32'd0);
        checkOutput("busyAfterDone", 32'(busy), 32'd0);
    endtask

    task automatic randomSession(input int nCycles);
        startSession();
        for (int c = 0; c < nCycles; c++) begin
            in_valid   = ($urandom % 3) != 0;
            in_mnem    = ($urandom % 12 == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
            in_rs      = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
            in_rt      = 5'($urandom);
            in_rd      = 5'($urandom);
            in_shamt   = ($urandom % 2 == 0) ? 5'd0 : 5'($urandom);
            in_imm     = 16'($urandom);
            in_target  = 26'($urandom);
            imem_ready = ($urandom % 4) != 0;
            tick();
        end
        endSession();
    endtask

    initial begin
        bit        pb;
        bit [31:0] w;

        modelEncode(int'(MN_ADD), 1, 2, 3, 0, 0, 0, pb, w);
        checkOutput("modelAdd", w, 32'h0022_1820);
        modelEncode(int'(MN_LW), 9, 8, 0, 0, 16'd4, 0, pb, w);
        checkOutput("modelLw", w, 32'h8D28_0004);
        modelEncode(int'(MN_SLL), 0, 2, 3, 4, 0, 0, pb, w);
        checkOutput("modelSll", w, 32'h0002_1900);

        repeat (2) tick();
        checkOutput("rstInReady", 32'(in_ready), 32'd0);
        checkOutput("rstWe", 32'(imem_we), 32'd0);
        checkOutput("rstAddr", 32'(imem_addr), 32'(BASE));
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstCnt", 32'(word_cnt), 32'd0);
        rst = 1'b0;
        tick();

        startSession();
        applyStimulus(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        checkOutput("addWe", 32'(imem_we), 32'd1);
        checkOutput("addAddr", 32'(imem_addr), 32'd0);
        checkOutput("addData", imem_wdata, 32'h0022_1820);
        endSession();

        startSession();
        applyStimulus(MN_LW,  5'd9, 5'd8, 5'd0, 5'd0, 16'd4, 26'd0);
        applyStimulus(MN_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0);
        applyStimulus(MN_J,   5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100);
        endSession();
        checkOutput("progCnt", 32'(word_cnt), 32'd3);
        checkOutput("progLen", logData.size(), 32'd3);
        if (logData.size() == 3) begin
            checkOutput("progW0", logData[0], 32'h8D28_0004);
            checkOutput("progW1", logData[1], 32'h1022_FFFF);
            checkOutput("progW2", logData[2], 32'h0800_0100);
            checkOutput("progA2", 32'(logAddr[2]), 32'd2);
        end

        imem_ready = 1'b0;
        startSession();
        applyStimulus(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        applyStimulus(MN_LW,  5'd9, 5'd8, 5'd0, 5'd0, 16'd4, 26'd0);
        applyStimulus(MN_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0);
        applyStimulus(MN_J,   5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100);
        checkOutput("fullReady", 32'(in_ready), 32'd0);
        in_mnem = MN_NOP; in_valid = 1'b1;
        repeat (2) tick();
        checkOutput("stallAddr", 32'(imem_addr), 32'd0);
        checkOutput("stallData", imem_wdata, 32'h0022_1820);
        imem_ready = 1'b1;
        applyStimulus(MN_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        endSession();
        checkOutput("wrapFlag", 32'(wrap), 32'd1);
        checkOutput("wrapLen", logData.size(), 32'd5);
        if (logData.size() == 5) begin
            checkOutput("wrapA3", 32'(logAddr[3]), 32'd3);
            checkOutput("wrapA4", 32'(logAddr[4]), 32'd0);
            checkOutput("wrapW3", logData[3], 32'h0800_0100);
        end

        imem_ready = 1'b0;
        startSession();
        applyStimulus(MN_ORI,  5'd4, 5'd5, 5'd0, 5'd0, 16'h1234, 26'd0);
        applyStimulus(MN_SRA,  5'd0, 5'd6, 5'd7, 5'd2, 16'd0, 26'd0);
        applyStimulus(MN_SW,   5'd29, 5'd31, 5'd0, 5'd0, 16'h0008, 26'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("drainBusy", 32'(busy), 32'd1);
        checkOutput("drainWe", 32'(imem_we), 32'd1);
        endSession();
        checkOutput("drainCnt", 32'(word_cnt), 32'd3);

        startSession();
        applyStimulus(5'h1F, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        endSession();
        if (CHECK_EN) begin
            checkOutput("illegalErr", 32'(err), 32'd1);
            checkOutput("illegalCnt", 32'(word_cnt), 32'd0);
        end else begin
            checkOutput("illegalErr", 32'(err), 32'd0);
            checkOutput("illegalCnt", 32'(word_cnt), 32'd1);
            if (logData.size() == 1) checkOutput("illegalWord", logData[0], 32'h0);
        end

        imem_ready = 1'b0;
        startSession();
        applyStimulus(MN_ADDI, 5'd1, 5'd1, 5'd0, 5'd0, 16'd7, 26'd0);
        applyStimulus(MN_XOR,  5'd2, 5'd3, 5'd4, 5'd0, 16'd0, 26'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRstWe", 32'(imem_we), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstCnt", 32'(word_cnt), 32'd0);
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("midRstNoDone", 32'(done), 32'd0);
            tick();
        end

        for (int s = 0; s < 10; s++)
            randomSession(20 + s * 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential MIPS-32 instruction encoder and instruction-memory loader, the write-side counterpart of the opcode decoder in the control path. It accepts one symbolic instruction per handshake (mnemonic plus register/immediate/target fields), packs it into the 32-bit R/I/J word the decoder consumes, buffers it in a small FIFO and writes it into instruction memory at an auto-incrementing word address. The bench and boot logic use it to load programs without hand-assembled hex.

## Interface
- FIFO_DEPTH, 4, encoded-word buffer depth; power of 2, ≥2
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first write address after `start`
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  arm a load session; ignored unless IDLE
- flush  in  1  end of program; ignored unless LOAD
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept
- in_mnem  in  5  mnemonic code (package enum)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  16  immediate / branch offset (word units)
- in_target  in  26  jump target field
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts the write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded word
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, session complete
- wrap  out  1  sticky: address wrapped during session
- err  out  1  sticky: illegal input dropped (ENC_ILLEGAL_CHECK_EN only)
- word_cnt  out  ADDR_W+1  words written this session

## Operation
- Encoding: R-type op=000000 {op,rs,rt,rd,shamt,funct}; funct add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, slt 101010, sltu 101011, sll 000000, srl 000010, sra 000011. For add..sltu, shamt is forced to 0. For sll/srl/sra, rs is forced to 0.
- I-type {op,rs,rt,imm}: addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101.
- J-type {000010,target}. NOP mnemonic → 32'h00000000.
- FSM states:
  - IDLE –start→ LOAD. On this transition imem_addr←BASE_ADDR, word_cnt←0, wrap←0, err←0.
  - LOAD –flush→ DRAIN.
  - DRAIN –FIFO empty→ DONE.
  - DONE → IDLE unconditionally. done=1 only in DONE.
- in_ready = (state==LOAD) && FIFO not full. Accept = in_valid && in_ready. The encoded word is pushed the same edge.
- If flush and accept coincide, the instruction is taken, then DRAIN.
- Writer: imem_we = FIFO not empty. imem_wdata = FIFO head (show-ahead).
- On imem_we && imem_ready: pop, imem_addr+1, word_cnt+1.
- imem_addr wraps from 2^ADDR_W−1 to 0 and sets wrap. Writes continue.
- Push and pop in the same cycle are legal at any non-full occupancy. Occupancy is unchanged.
- imem_we, imem_addr and imem_wdata are held stable while imem_ready=0.
- start/flush are ignored outside the listed states. in_valid outside LOAD is ignored.

## Timing
- Reset values: state IDLE; in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, busy 0, done 0, wrap 0, err 0, word_cnt 0; FIFO empty.
- Latency: accept at edge N → imem_we=1 with that word in the cycle after edge N.
- Throughput: 1 word/cycle with imem_ready held at 1.
- Full FIFO: in_ready=0 combinationally until a pop.
- rst mid-session: FIFO contents are discarded, there is no done pulse, and the block returns to the reset values on the next edge.

## Configuration
- ENC_ILLEGAL_CHECK_EN defined:
  - Undefined mnemonic codes are detected at accept, and so are nonzero in_shamt on non-shift R-types and nonzero in_rs on shifts.
  - Such an instruction is consumed, not pushed, and sets err.
- ENC_ILLEGAL_CHECK_EN undefined:
  - Undefined mnemonics encode to 32'h00000000.
  - The field-forcing rules above apply.
  - err is tied to 0.

## Structure
- Package mips_enc_pkg holds:
  - the mnemonic enum (5-bit)
  - opcode and funct localparams
  - the FSM state enum
- These constants are shared with the decoder bench.
- One sub-module, enc_fifo: parameterised synchronous show-ahead FIFO with push/pop/full/empty.
- The encode function and FSM live in the top.

## Test plan
- Reset then start; push add $3,$1,$2 with imem_ready=1 → one cycle later imem_we=1, addr 0, wdata 32'h00221820.
- Push lw $8,4($9), beq $1,$2,−1, j 0x100 → words 32'h8D280004, 32'h1022FFFF, 32'h08000100 at addrs 0,1,2; word_cnt=3.
- imem_ready=0 for 6 cycles while pushing → in_ready falls after FIFO_DEPTH accepts; outputs stay stable; all words arrive in order after release.
- ADDR_W=2: write 5 words → addresses 0,1,2,3,0; wrap=1.
- flush with 3 words queued → DRAIN until all written, then done high exactly 1 cycle, busy low the cycle after.
- With ENC_ILLEGAL_CHECK_EN, mnemonic 5'h1F → err=1, no write. Without it → 32'h00000000 written. Assert rst mid-DRAIN → no done; outputs at reset values.
